// File: rtl/icache_pkg.sv
// Shared definitions for the instruction cache.
//   ADDR_WIDTH / INS_WIDTH : address and instruction word widths
//   state_e                : controller states
//   word_align()           : clears the byte offset of a fetch address
package icache_pkg;

    localparam int unsigned ADDR_WIDTH = 32;
    localparam int unsigned INS_WIDTH  = 32;

    typedef enum logic [1:0] {
        StIdle = 2'd0,
        StMiss = 2'd1,
        StDone = 2'd2
    } state_e;

    function automatic logic [ADDR_WIDTH-1:0] word_align(input logic [ADDR_WIDTH-1:0] addr);
        return {addr[ADDR_WIDTH-1:2], 2'b00};
    endfunction

endpackage

// File: rtl/icache_if.sv
// Bus bundle around the instruction cache.
//   Fetcher side : req_from_if, pc_from_if  -> cache
//                  ins_ready_to_if, ins_to_if <- cache
//   Memctrl side : enable_to_mc, addr_to_mc  <- cache
//                  done_from_mc, ins_from_mc -> cache
// modport master : the cache itself
// modport slave  : the surrounding fetcher + memory controller
interface icache_if;
    import icache_pkg::*;

    logic                  req_from_if;
    logic [ADDR_WIDTH-1:0] pc_from_if;
    logic                  ins_ready_to_if;
    logic [INS_WIDTH-1:0]  ins_to_if;
    logic                  enable_to_mc;
    logic [ADDR_WIDTH-1:0] addr_to_mc;
    logic                  done_from_mc;
    logic [INS_WIDTH-1:0]  ins_from_mc;

    modport master (
        input  req_from_if,
        input  pc_from_if,
        output ins_ready_to_if,
        output ins_to_if,
        output enable_to_mc,
        output addr_to_mc,
        input  done_from_mc,
        input  ins_from_mc
    );

    modport slave (
        output req_from_if,
        output pc_from_if,
        input  ins_ready_to_if,
        input  ins_to_if,
        input  enable_to_mc,
        input  addr_to_mc,
        output done_from_mc,
        output ins_from_mc
    );

endinterface

// File: rtl/icache_array.sv
// Storage for the direct-mapped instruction cache: one valid bit, tag and
// 32-bit word per line.
//   clk, rst             : clock; async active-high reset clears valid bits only
//   rd_idx               : asynchronous read index
//   rd_valid/tag/data    : contents of line rd_idx
//   wr_en/idx/tag/data   : synchronous write port, sets the line valid
module icache_array
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8,
    parameter int unsigned TAG_BITS   = ADDR_WIDTH - INDEX_BITS - 2
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [INDEX_BITS-1:0] rd_idx,
    output logic                  rd_valid,
    output logic [TAG_BITS-1:0]   rd_tag,
    output logic [INS_WIDTH-1:0]  rd_data,
    input  logic                  wr_en,
    input  logic [INDEX_BITS-1:0] wr_idx,
    input  logic [TAG_BITS-1:0]   wr_tag,
    input  logic [INS_WIDTH-1:0]  wr_data
);

    localparam int unsigned Lines = 1 << INDEX_BITS;

    logic [Lines-1:0]     valid_q;
    logic [TAG_BITS-1:0]  tag_q  [Lines];
    logic [INS_WIDTH-1:0] data_q [Lines];

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_idx] <= 1'b1;
        end
    end

    // Tag/data need no reset: a line is only consulted once its valid bit is set.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            tag_q[wr_idx]  <= wr_tag;
            data_q[wr_idx] <= wr_data;
        end
    end

    assign rd_valid = valid_q[rd_idx];
    assign rd_tag   = tag_q[rd_idx];
    assign rd_data  = data_q[rd_idx];

endmodule

// File: rtl/icache.sv
// Direct-mapped instruction cache between the instruction fetcher and the
// memory controller. Hits return one cycle after the request; misses run the
// Memctrl handshake, fill the line and return the word, followed by a
// one-cycle bubble so the controller sees enable low before any new request.
//   clk   : clock, rising edge
//   rst   : asynchronous active-high reset
//   rdy   : global enable, low freezes all state and outputs
//   clear : flush, aborts any outstanding request (array kept)
//   bus   : fetcher and Memctrl signals (icache_if.master)
module icache
    import icache_pkg::*;
#(
    parameter int unsigned INDEX_BITS = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  logic     rdy,
    input  logic     clear,
    icache_if.master bus
);

    localparam int unsigned TAG_BITS = ADDR_WIDTH - INDEX_BITS - 2;

    state_e                state_q, state_d;
    logic                  ins_ready_q, ins_ready_d;
    logic [INS_WIDTH-1:0]  ins_q, ins_d;
    logic                  enable_q, enable_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;

    logic [INDEX_BITS-1:0] lu_idx;
    logic [TAG_BITS-1:0]   lu_tag;
    logic                  rd_valid;
    logic [TAG_BITS-1:0]   rd_tag;
    logic [INS_WIDTH-1:0]  rd_data;
    logic                  hit;
    logic                  fill;

    logic unused_pc_offset;
    assign unused_pc_offset = ^bus.pc_from_if[1:0];

    assign lu_idx = bus.pc_from_if[INDEX_BITS+1:2];
    assign lu_tag = bus.pc_from_if[ADDR_WIDTH-1:INDEX_BITS+2];
    assign hit    = rd_valid && (rd_tag == lu_tag);

    // The fill address is taken from addr_q, which still holds the miss
    // address on the edge that samples done_from_mc.
    icache_array #(
        .INDEX_BITS (INDEX_BITS),
        .TAG_BITS   (TAG_BITS)
    ) u_array (
        .clk      (clk),
        .rst      (rst),
        .rd_idx   (lu_idx),
        .rd_valid (rd_valid),
        .rd_tag   (rd_tag),
        .rd_data  (rd_data),
        .wr_en    (fill && rdy),
        .wr_idx   (addr_q[INDEX_BITS+1:2]),
        .wr_tag   (addr_q[ADDR_WIDTH-1:INDEX_BITS+2]),
        .wr_data  (bus.ins_from_mc)
    );

    always_comb begin
        state_d     = state_q;
        ins_ready_d = 1'b0;
        ins_d       = ins_q;
        enable_d    = enable_q;
        addr_d      = addr_q;
        fill        = 1'b0;

        if (clear) begin
            // Abort: drops the request and any data arriving this cycle.
            state_d  = StIdle;
            enable_d = 1'b0;
            addr_d   = '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (bus.req_from_if) begin
                        if (hit) begin
                            ins_d       = rd_data;
                            ins_ready_d = 1'b1;
                        end else begin
                            enable_d = 1'b1;
                            addr_d   = word_align(bus.pc_from_if);
                            state_d  = StMiss;
                        end
                    end
                end
                StMiss: begin
                    if (bus.done_from_mc) begin
                        fill        = 1'b1;
                        ins_d       = bus.ins_from_mc;
                        ins_ready_d = 1'b1;
                        // Must drop on this edge or Memctrl restarts the fetch.
                        enable_d    = 1'b0;
                        addr_d      = '0;
                        state_d     = StDone;
                    end
                end
                StDone: begin
                    state_d = StIdle;
                end
                default: begin
                    state_d = StIdle;
                end
            endcase
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= StIdle;
            ins_ready_q <= 1'b0;
            ins_q       <= '0;
            enable_q    <= 1'b0;
            addr_q      <= '0;
        end else if (rdy) begin
            state_q     <= state_d;
            ins_ready_q <= ins_ready_d;
            ins_q       <= ins_d;
            enable_q    <= enable_d;
            addr_q      <= addr_d;
        end
    end

    assign bus.ins_ready_to_if = ins_ready_q;
    assign bus.ins_to_if       = ins_q;
    assign bus.enable_to_mc    = enable_q;
    assign bus.addr_to_mc      = addr_q;

endmodule
